aha_tick_gen: RTL and testbench
===============================

Name: aha_tick_gen

Overview:
Programmable tick generator that produces the single-cycle enable strobe for the team's enable-gated event/cycle counters. Its TICK output connects directly to a downstream counter's EN input.
- Divides CLK by a programmable ratio (DIV+1).
- Runs either free-running or for a fixed burst of ticks.
- Start and stop are pulse-driven.
- Reports BUSY status and a DONE pulse when a burst completes.

Parameters:
DIV_WIDTH, 16, width of the divider setting and of the internal prescaler counter
CNT_WIDTH, 16, width of the burst length and of the remaining-tick counter

Ports:
CLK  input  1  clock
RESETn  input  1  reset, asynchronous, active-low
START  input  1  start request pulse; sampled only in IDLE
STOP  input  1  stop request pulse; honoured in IDLE and RUN
MODE  input  1  0 = free-run, 1 = burst; latched on accepted START
DIV  input  DIV_WIDTH  tick period minus one; latched on accepted START
BURST_LEN  input  CNT_WIDTH  number of ticks in burst mode; latched on accepted START
TICK  output  1  enable strobe to the downstream counter; one cycle high per period
BUSY  output  1  high while in RUN
DONE  output  1  one-cycle pulse after the last tick of a completed burst

Behaviour:
- Reset (RESETn low, asynchronous):
  - State goes to IDLE.
  - Prescaler count, remaining count and latched config are cleared.
  - TICK=0, BUSY=0, DONE=0.
  - Reset asserted mid-run aborts immediately, with no DONE pulse.
- States:
  - IDLE: TICK=0, BUSY=0.
  - RUN: BUSY=1.
- IDLE -> RUN:
  - Transition happens at the edge where START=1, STOP=0, and NOT (MODE=1 and BURST_LEN=0).
  - At that edge: DIV, MODE and BURST_LEN are latched (div_q, mode_q, rem_q). Prescaler count is set to 0.
- START with MODE=1 and BURST_LEN=0:
  - State stays IDLE.
  - DONE=1 in the following cycle. No TICK. BUSY never asserts.
- START and STOP high together in IDLE: STOP wins; nothing happens.
- TICK logic:
  - TICK = (state==RUN) && (presc==div_q). This is a decoded output; it is not delayed by a register.
  - In RUN on each edge: if presc==div_q then presc<=0, else presc<=presc+1.
  - The first TICK occurs div_q+1 cycles after the START edge. The period is div_q+1 cycles.
  - DIV=0 gives TICK every RUN cycle, starting in the cycle right after the START edge.
  - DIV = all-ones is legal. The period is 2^DIV_WIDTH, and presc never overflows because it is compared before it increments.
- Burst mode (mode_q=1):
  - Each TICK decrements rem_q.
  - On a TICK cycle with rem_q==1, the next edge goes to IDLE and DONE=1 for exactly the following cycle.
  - Exactly BURST_LEN ticks are emitted.
- Free-run mode (mode_q=0): rem_q is ignored and ticks continue until STOP.
- STOP in RUN:
  - The next edge goes to IDLE. DONE is not asserted.
  - If TICK is high in the same cycle, that tick is still delivered.
  - If STOP coincides with the final burst tick, completion wins: DONE pulses.
- START while in RUN is ignored, including its config.
- DIV, MODE and BURST_LEN changes during RUN have no effect.
- DONE is a register. It is cleared every cycle unless set by burst completion.
- Arithmetic: all counters are unsigned, at their declared widths. No wrap is ever reachable by construction.

Decomposition:
- Shared package aha_tick_pkg holds:
  - state enum (TICK_IDLE, TICK_RUN)
  - mode constants (TICK_MODE_FREE=1'b0, TICK_MODE_BURST=1'b1)
- One sub-module, aha_tick_prescaler:
  - Contents: the DIV_WIDTH counter with clear, enable and terminal-count compare.
  - Outputs: a terminal-count (tc) flag.
  - The FSM, burst counter and DONE logic stay in the top module.

Test Plan:
- Reset mid-run:
  - Stimulus: MODE=0, DIV=3, pulse START, run 20 cycles, then assert RESETn low asynchronously between edges.
  - Before reset: TICK on cycles 4, 8, 12, 16, 20 after START (counting the START edge as cycle 0).
  - At reset: TICK, BUSY and DONE go low immediately. No DONE pulse.
- Burst of 3 with DIV=0:
  - Stimulus: BURST_LEN=3, DIV=0.
  - TICK high in cycles 1, 2 and 3. BUSY high in cycles 1–3. DONE high only in cycle 4. Exactly 3 ticks.
- Burst of 5 with DIV=2 driving a downstream 8-bit enable counter:
  - Counter ends at 5. Ticks at cycles 3, 6, 9, 12, 15. DONE at cycle 16.
- Zero-length burst:
  - Stimulus: MODE=1, BURST_LEN=0, START.
  - DONE high in cycle 1 only. BUSY and TICK stay 0.
- STOP collisions:
  - STOP coincident with a free-run TICK: that TICK is seen and no further ticks follow. BUSY drops the next cycle. DONE stays 0.
  - STOP on the final burst tick: DONE pulses.
- Ignored inputs:
  - START re-pulsed during RUN with a new DIV=7: period stays at the original div_q+1.
  - START+STOP together in IDLE: stays IDLE.
  - Maximum DIV (16'hFFFF), free-run: first TICK exactly 65536 cycles after START.

Source files
------------

// File: rtl/aha_tick_pkg.sv
// Shared types for the tick generator.
// State encoding and run-mode constants.
package aha_tick_pkg;

  typedef enum logic {
    TICK_IDLE = 1'b0,
    TICK_RUN  = 1'b1
  } tick_state_e;

  localparam logic TICK_MODE_FREE  = 1'b0;
  localparam logic TICK_MODE_BURST = 1'b1;

endpackage

// File: rtl/aha_tick_prescaler.sv
// Prescaler counter for the tick generator.
// Counts 0..div_i and flags terminal count.
module aha_tick_prescaler #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 CLK,
  input  logic                 RESETn,
  input  logic                 clr_i,
  input  logic                 en_i,
  input  logic [DIV_WIDTH-1:0] div_i,
  output logic                 tc_o
);

  logic [DIV_WIDTH-1:0] count_q;
  logic [DIV_WIDTH-1:0] count_d;

  // Compare before increment so an all-ones divider never overflows.
  assign tc_o = (count_q == div_i);

  // Next count: clear, wrap on terminal count, else advance.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      if (tc_o) count_d = '0;
      else      count_d = count_q + DIV_WIDTH'(1);
    end
  end

  // Count register.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) count_q <= '0;
    else         count_q <= count_d;
  end

endmodule

// File: rtl/aha_tick_gen.sv
// Programmable tick generator.
// Free-run or burst enable strobe with BUSY/DONE.
module aha_tick_gen
  import aha_tick_pkg::*;
#(
  parameter int DIV_WIDTH = 16,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 CLK,
  input  logic                 RESETn,
  input  logic                 START,
  input  logic                 STOP,
  input  logic                 MODE,
  input  logic [DIV_WIDTH-1:0] DIV,
  input  logic [CNT_WIDTH-1:0] BURST_LEN,
  output logic                 TICK,
  output logic                 BUSY,
  output logic                 DONE
);

  tick_state_e          state_q, state_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic                 mode_q, mode_d;
  logic [CNT_WIDTH-1:0] rem_q, rem_d;
  logic                 done_q, done_d;
  logic                 tc;
  logic                 run;

  assign run  = (state_q == TICK_RUN);
  assign TICK = run && tc;
  assign BUSY = run;
  assign DONE = done_q;

  // Prescaler held at zero while idle so a run starts from 0.
  aha_tick_prescaler #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_presc (
    .CLK    (CLK),
    .RESETn (RESETn),
    .clr_i  (!run),
    .en_i   (run),
    .div_i  (div_q),
    .tc_o   (tc)
  );

  // Next state, config latch, burst countdown and completion.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    mode_d  = mode_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    unique case (state_q)
      TICK_IDLE: begin
        if (START && !STOP) begin
          if (MODE == TICK_MODE_BURST && BURST_LEN == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = TICK_RUN;
            div_d   = DIV;
            mode_d  = MODE;
            rem_d   = BURST_LEN;
          end
        end
      end
      TICK_RUN: begin
        if (STOP) state_d = TICK_IDLE;
        if (TICK && mode_q == TICK_MODE_BURST) begin
          rem_d = rem_q - CNT_WIDTH'(1);
          if (rem_q == CNT_WIDTH'(1)) begin
            state_d = TICK_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = TICK_IDLE;
    endcase
  end

  // State and config registers.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q <= TICK_IDLE;
      div_q   <= '0;
      mode_q  <= TICK_MODE_FREE;
      rem_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      mode_q  <= mode_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_aha_tick_gen.sv
// Testbench for aha_tick_gen.
// Cycle-level reference model plus directed and random runs.
module tb_aha_tick_gen;

  logic        CLK = 1'b0;
  logic        RESETn = 1'b0;
  logic        START = 1'b0;
  logic        STOP = 1'b0;
  logic        MODE = 1'b0;
  logic [15:0] DIV = '0;
  logic [15:0] BURST_LEN = '0;
  logic        TICK, BUSY, DONE;

  int checks = 0;
  int errors = 0;

  aha_tick_gen #(
    .DIV_WIDTH (16),
    .CNT_WIDTH (16)
  ) dut (
    .CLK       (CLK),
    .RESETn    (RESETn),
    .START     (START),
    .STOP      (STOP),
    .MODE      (MODE),
    .DIV       (DIV),
    .BURST_LEN (BURST_LEN),
    .TICK      (TICK),
    .BUSY      (BUSY),
    .DONE      (DONE)
  );

  always #5 CLK = ~CLK;

  // Reference model: run flag, cycles since start, period, ticks left.
  bit      m_run = 0;
  longint  m_k = 0;
  longint  m_per = 1;
  bit      m_burst = 0;
  longint  m_left = 0;
  bit      m_done = 0;
  int      cnt8 = 0;

  function automatic bit exp_tick();
    return m_run && ((m_k % m_per) == 0);
  endfunction

  initial begin
    forever begin
      @(posedge CLK or negedge RESETn);
      if (!RESETn) begin
        m_run = 0; m_k = 0; m_per = 1;
        m_burst = 0; m_left = 0; m_done = 0;
      end else begin
        bit t;
        bit nd;
        t = exp_tick();
        nd = 0;
        if (TICK) cnt8 = (cnt8 + 1) % 256;
        if (!m_run) begin
          if (START && !STOP) begin
            if (MODE && BURST_LEN == 0) begin
              nd = 1;
            end else begin
              m_run = 1; m_k = 1;
              m_per = longint'(DIV) + 1;
              m_burst = MODE;
              m_left = longint'(BURST_LEN);
            end
          end
        end else begin
          if (t && m_burst) m_left = m_left - 1;
          if (t && m_burst && m_left == 0) begin
            m_run = 0; nd = 1;
          end else if (STOP) begin
            m_run = 0;
          end else begin
            m_k = m_k + 1;
          end
        end
        m_done = nd;
      end
    end
  end

  task automatic check(input string name, input longint act,
                       input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Per-cycle compare against the model.
  initial begin
    forever begin
      @(negedge CLK);
      if (RESETn)
        check("cycle_tbd", {TICK, BUSY, DONE},
              {exp_tick(), m_run, m_done});
    end
  end

  int tq[$];
  int dq[$];
  int bq[$];

  task automatic obs(input int first, input int n);
    tq.delete(); dq.delete(); bq.delete();
    for (int i = first; i < first + n; i++) begin
      @(negedge CLK);
      if (TICK) tq.push_back(i);
      if (DONE) dq.push_back(i);
      if (BUSY) bq.push_back(i);
    end
  endtask

  task automatic check_q(input string name, input int q[$],
                         input int e[$]);
    check({name, "_len"}, q.size(), e.size());
    for (int i = 0; i < q.size() && i < e.size(); i++)
      check(name, q[i], e[i]);
  endtask

  task automatic start_pulse(input bit m, input logic [15:0] d,
                             input logic [15:0] l);
    @(posedge CLK); #1;
    START = 1; MODE = m; DIV = d; BURST_LEN = l;
    @(posedge CLK); #1;
    START = 0;
  endtask

  task automatic stop_pulse();
    @(posedge CLK); #1 STOP = 1;
    @(posedge CLK); #1 STOP = 0;
    repeat (2) @(posedge CLK);
  endtask

  initial begin
    #12;
    check("reset_tick", TICK, 0);
    check("reset_busy", BUSY, 0);
    check("reset_done", DONE, 0);
    RESETn = 1;

    // Free run DIV=3, then asynchronous reset mid-run.
    start_pulse(0, 16'd3, 16'd0);
    obs(1, 20);
    check_q("rst_ticks", tq, '{4, 8, 12, 16, 20});
    #2 RESETn = 0;
    #1;
    check("rst_tick_low", TICK, 0);
    check("rst_busy_low", BUSY, 0);
    check("rst_done_low", DONE, 0);
    @(posedge CLK); #1;
    check("rst_done_held", DONE, 0);
    #3 RESETn = 1;
    obs(0, 3);
    check("rst_no_done", dq.size(), 0);

    // Burst of 3, DIV=0.
    start_pulse(1, 16'd0, 16'd3);
    obs(1, 6);
    check_q("b3_ticks", tq, '{1, 2, 3});
    check_q("b3_busy", bq, '{1, 2, 3});
    check_q("b3_done", dq, '{4});

    // Burst of 5, DIV=2, into an 8-bit enable counter.
    cnt8 = 0;
    start_pulse(1, 16'd2, 16'd5);
    obs(1, 18);
    check_q("b5_ticks", tq, '{3, 6, 9, 12, 15});
    check_q("b5_done", dq, '{16});
    check("b5_count", cnt8, 5);

    // Zero-length burst.
    start_pulse(1, 16'd4, 16'd0);
    obs(1, 4);
    check_q("z_done", dq, '{1});
    check("z_ticks", tq.size(), 0);
    check("z_busy", bq.size(), 0);

    // STOP on a free-run tick (DIV=1: ticks at 2,4,...).
    start_pulse(0, 16'd1, 16'd0);
    obs(1, 3);
    @(posedge CLK); #1 STOP = 1;
    @(negedge CLK);
    check("stopf_tick", TICK, 1);
    @(posedge CLK); #1 STOP = 0;
    @(negedge CLK);
    check("stopf_busy", BUSY, 0);
    check("stopf_done", DONE, 0);
    obs(6, 6);
    check("stopf_after", tq.size() + dq.size(), 0);

    // STOP on the final burst tick.
    start_pulse(1, 16'd1, 16'd2);
    obs(1, 3);
    @(posedge CLK); #1 STOP = 1;
    @(negedge CLK);
    check("stopb_tick", TICK, 1);
    @(posedge CLK); #1 STOP = 0;
    @(negedge CLK);
    check("stopb_done", DONE, 1);
    check("stopb_busy", BUSY, 0);

    // START re-pulsed during RUN with a new DIV.
    start_pulse(0, 16'd1, 16'd0);
    @(posedge CLK); #1;
    START = 1; DIV = 16'd7; MODE = 1; BURST_LEN = 16'd1;
    @(posedge CLK); #1 START = 0;
    obs(3, 8);
    check_q("rs_ticks", tq, '{4, 6, 8, 10});
    stop_pulse();

    // START and STOP together in IDLE.
    @(posedge CLK); #1;
    START = 1; STOP = 1; MODE = 0; DIV = 16'd0;
    @(posedge CLK); #1;
    START = 0; STOP = 0;
    obs(1, 4);
    check("ss_busy", bq.size(), 0);
    check("ss_done", dq.size(), 0);

    // Maximum DIV.
    start_pulse(0, 16'hFFFF, 16'd0);
    obs(1, 65537);
    check_q("max_ticks", tq, '{65536});
    stop_pulse();

    // Random traffic; the per-cycle compare does the checking.
    for (int i = 0; i < 3000; i++) begin
      @(posedge CLK); #1;
      START = ($urandom_range(0, 7) == 0);
      STOP = ($urandom_range(0, 24) == 0);
      MODE = 1'($urandom_range(0, 1));
      DIV = 16'($urandom_range(0, 5));
      BURST_LEN = 16'($urandom_range(0, 6));
    end
    @(posedge CLK); #1;
    START = 0; STOP = 0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
